ddr4_cmd_responder: RTL

DDR4_CMD_RESPONDER -- requirements
Module: ddr4_cmd_responder

---
 rtl/ddr4_cmd_responder.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ddr4_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module   : ddr4_cmd_responder
// Purpose  : Behavioural DDR4 device-side command responder. Tracks per-bank
//            open/row/timing state, schedules read data (CL) and write-data
//            capture (CWL) through fixed-latency pipelines into a 32x64
//            storage array, runs refresh busy timing and flags the first
//            protocol error.
// Ports    : clk, reset_n (synchronous, active low)
//            phy_cmd/phy_addr/phy_bank/phy_bg/phy_act_n/phy_cs_n : command bus
//            wr_data / wr_data_req : write data and its capture strobe
//            rd_data / rd_data_valid : read data and its qualifier
//            bank_open : per-bank open flags, index {phy_bg,phy_bank}
//            busy : refresh in progress
//            err_flag / err_code : sticky first protocol error
// Revision : 1.0 - initial release
// ============================================================================
module ddr4_cmd_responder #(
    parameter int CL   = 4,
    parameter int CWL  = 3,
    parameter int TRCD = 3,
    parameter int TRP  = 3,
    parameter int TRFC = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  phy_cmd,
    input  logic [15:0] phy_addr,
    input  logic [1:0]  phy_bank,
    input  logic        phy_bg,
    input  logic        phy_act_n,
    input  logic        phy_cs_n,
    input  logic [63:0] wr_data,
    output logic        wr_data_req,
    output logic [63:0] rd_data,
    output logic        rd_data_valid,
    output logic [7:0]  bank_open,
    output logic        busy,
    output logic        err_flag,
    output logic [2:0]  err_code
);

    localparam logic [2:0] c_cmd_mrs = 3'b000;
    localparam logic [2:0] c_cmd_ref = 3'b001;
    localparam logic [2:0] c_cmd_pre = 3'b010;
    localparam logic [2:0] c_cmd_act = 3'b011;
    localparam logic [2:0] c_cmd_wr  = 3'b100;
    localparam logic [2:0] c_cmd_rd  = 3'b101;
    localparam logic [2:0] c_cmd_zq  = 3'b110;
    localparam logic [2:0] c_cmd_nop = 3'b111;

    // The command cycle itself counts toward the delay: an ACT at T makes
    // RD/WR legal at T+TRCD, which is exactly when a timer loaded with
    // TRCD-1 at the ACT edge has counted down to zero.
    localparam logic [3:0] c_trcd_ld = (TRCD > 1) ? 4'(TRCD - 1) : 4'd0;
    localparam logic [3:0] c_trp_ld  = (TRP > 1)  ? 4'(TRP - 1)  : 4'd0;
    localparam logic [7:0] c_trfc    = 8'(TRFC);

    logic [7:0]     r_open;
    logic [15:0]    r_row   [8];
    logic [3:0]     r_timer [8];
    logic [7:0]     r_ref_cnt;
    logic [CL-1:0]  r_rd_v;
    logic [4:0]     r_rd_idx [CL];
    logic [CWL-1:0] r_wr_v;
    logic [4:0]     r_wr_idx [CWL];
    logic [63:0]    r_mem   [32];
    logic           r_err_flag;
    logic [2:0]     r_err_code;

    logic [2:0] w_bank;
    logic [4:0] w_idx;
    logic       w_busy;
    logic [2:0] w_err;
    logic       w_exec;
    logic       w_act_issue;
    logic       w_pre_issue;
    logic       w_ref_issue;
    logic       w_rd_issue;
    logic       w_wr_issue;
    logic       w_unused_row;

    // Command decode and error classification, highest priority first.
    always_comb begin
        w_bank = {phy_bg, phy_bank};
        w_idx  = {phy_bg, phy_bank, phy_addr[1:0]};
        w_busy = (r_ref_cnt != 8'd0);
        w_err  = 3'd0;
        if (!phy_cs_n) begin
            if ((phy_cmd == c_cmd_act) == phy_act_n) begin
                w_err = 3'd6;
            end else if (w_busy && (phy_cmd != c_cmd_nop)) begin
                w_err = 3'd5;
            end else if ((phy_cmd == c_cmd_act) && r_open[w_bank]) begin
                w_err = 3'd1;
            end else if (((phy_cmd == c_cmd_rd) || (phy_cmd == c_cmd_wr)) && !r_open[w_bank]) begin
                w_err = 3'd2;
            end else if (((phy_cmd == c_cmd_ref) || (phy_cmd == c_cmd_mrs) ||
                          (phy_cmd == c_cmd_zq)) && (|r_open)) begin
                w_err = 3'd4;
            end else if (((phy_cmd == c_cmd_act) || (phy_cmd == c_cmd_rd) ||
                          (phy_cmd == c_cmd_wr)) && (r_timer[w_bank] != 4'd0)) begin
                w_err = 3'd3;
            end
        end
        w_exec      = !phy_cs_n && (w_err == 3'd0);
        w_act_issue = w_exec && (phy_cmd == c_cmd_act);
        w_pre_issue = w_exec && (phy_cmd == c_cmd_pre);
        w_ref_issue = w_exec && (phy_cmd == c_cmd_ref);
        w_rd_issue  = w_exec && (phy_cmd == c_cmd_rd);
        w_wr_issue  = w_exec && (phy_cmd == c_cmd_wr);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_open     <= '0;
            r_ref_cnt  <= '0;
            r_rd_v     <= '0;
            r_wr_v     <= '0;
            r_err_flag <= 1'b0;
            r_err_code <= 3'd0;
            for (int i = 0; i < 8; i++) r_timer[i] <= 4'd0;
            for (int k = 0; k < CL; k++) r_rd_idx[k] <= 5'd0;
            for (int k = 0; k < CWL; k++) r_wr_idx[k] <= 5'd0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (r_timer[i] != 4'd0) r_timer[i] <= r_timer[i] - 4'd1;
            end
            if (w_busy) r_ref_cnt <= r_ref_cnt - 8'd1;

            // Fixed-latency shift pipelines; entries already in flight keep
            // moving regardless of any later PRE/REF.
            r_rd_v      <= {r_rd_v[CL-2:0], w_rd_issue};
            r_rd_idx[0] <= w_idx;
            for (int k = 1; k < CL; k++) r_rd_idx[k] <= r_rd_idx[k-1];
            r_wr_v      <= {r_wr_v[CWL-2:0], w_wr_issue};
            r_wr_idx[0] <= w_idx;
            for (int k = 1; k < CWL; k++) r_wr_idx[k] <= r_wr_idx[k-1];

            if (w_act_issue) begin
                r_open[w_bank]  <= 1'b1;
                r_timer[w_bank] <= c_trcd_ld;
            end
            // Closing an already-closed bank leaves its timer alone.
            if (w_pre_issue) begin
                for (int i = 0; i < 8; i++) begin
                    if ((phy_addr[10] || (w_bank == 3'(i))) && r_open[i]) begin
                        r_open[i]  <= 1'b0;
                        r_timer[i] <= c_trp_ld;
                    end
                end
            end
            if (w_ref_issue) r_ref_cnt <= c_trfc;

            if (!r_err_flag && (w_err != 3'd0)) begin
                r_err_flag <= 1'b1;
                r_err_code <= w_err;
            end
        end
    end

    // Row and data storage carry no reset.
    always_ff @(posedge clk) begin
        if (reset_n && w_act_issue) r_row[w_bank] <= phy_addr;
    end

    always_ff @(posedge clk) begin
        if (reset_n && r_wr_v[CWL-1]) r_mem[r_wr_idx[CWL-1]] <= wr_data;
    end

    // Read data is taken combinationally in the emit cycle so that a write
    // committing to the same location in that cycle is returned (write-first).
    always_comb begin
        rd_data = 64'd0;
        if (r_rd_v[CL-1]) begin
            if (r_wr_v[CWL-1] && (r_wr_idx[CWL-1] == r_rd_idx[CL-1])) begin
                rd_data = wr_data;
            end else begin
                rd_data = r_mem[r_rd_idx[CL-1]];
            end
        end
    end

    // The open row is held for completeness but drives no output.
    always_comb begin
        w_unused_row = 1'b0;
        for (int i = 0; i < 8; i++) w_unused_row = w_unused_row ^ (^r_row[i]);
    end

    assign rd_data_valid = r_rd_v[CL-1];
    assign wr_data_req   = r_wr_v[CWL-1];
    assign bank_open     = r_open;
    assign busy          = w_busy;
    assign err_flag      = r_err_flag;
    assign err_code      = r_err_code;

endmodule
`default_nettype wire
